// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared constants and state encoding for the instruction-fetch responder.
package inst_fetch_ctrl_pkg;

    localparam int unsigned INST_ADDR_W = 32;
    localparam int unsigned INST_W      = 32;
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned CNT_W       = 2;

    localparam logic RST_ENABLE   = 1'b1;
    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'b00,
        FETCH_BUSY = 2'b01,
        FETCH_LAST = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_ctrl.sv
// Fetches one 32-bit instruction as four big-endian bytes from a byte-wide
// synchronous memory, stalling the PC until the whole word is delivered.
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INST_ADDR_W-1:0] pc,
    input  logic                   ce,
    output logic                   stall,
    output logic                   mem_ce,
    output logic [INST_ADDR_W-1:0] mem_addr,
    input  logic [BYTE_W-1:0]      mem_data,
    output logic [INST_W-1:0]      inst,
    output logic                   inst_valid,
    output logic                   addr_err
);

    fetch_state_e             state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [INST_ADDR_W-1:2]   addr_q, addr_d;
    logic [INST_W-1:0]        shadow_q, shadow_d;
    logic [INST_W-1:0]        inst_q, inst_d;
    logic                     inst_valid_q, inst_valid_d;
    logic                     addr_err_q, addr_err_d;
    logic                     stall_q, stall_d;
    logic                     mem_ce_q, mem_ce_d;
    logic [INST_ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    // Read issued last cycle and its byte offset: data on mem_data now.
    logic                     rd_pend_q, rd_pend_d;
    logic [CNT_W-1:0]         rd_idx_q, rd_idx_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        shadow_d     = shadow_q;
        inst_d       = inst_q;
        inst_valid_d = 1'b0;
        addr_err_d   = 1'b0;
        rd_pend_d    = mem_ce_q;
        rd_idx_d     = mem_addr_q[CNT_W-1:0];

        if (rd_pend_q) begin
            case (rd_idx_q)
                2'd0:    shadow_d[31:24] = mem_data;
                2'd1:    shadow_d[23:16] = mem_data;
                2'd2:    shadow_d[15:8]  = mem_data;
                default: shadow_d[7:0]   = mem_data;
            endcase
        end

        case (state_q)
            FETCH_IDLE: begin
                if (ce == CHIP_ENABLE) begin
                    if (pc[1:0] == 2'b00) begin
                        state_d = FETCH_BUSY;
                        cnt_d   = '0;
                        addr_d  = pc[INST_ADDR_W-1:2];
                    end else begin
                        inst_d       = '0;
                        inst_valid_d = 1'b1;
                        addr_err_d   = 1'b1;
                    end
                end
            end
            FETCH_BUSY: begin
                cnt_d = CNT_W'(cnt_q + 1'b1);
                if (cnt_q == 2'd3) begin
                    state_d = FETCH_LAST;
                end
            end
            FETCH_LAST: begin
                // Publish the complete word only once byte 3 is merged in.
                state_d      = FETCH_IDLE;
                inst_d       = shadow_d;
                inst_valid_d = 1'b1;
            end
            default: begin
                state_d = FETCH_IDLE;
            end
        endcase

        stall_d    = (state_d != FETCH_IDLE);
        mem_ce_d   = (state_d == FETCH_BUSY);
        mem_addr_d = mem_ce_d ? {addr_d, cnt_d} : '0;
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q      <= FETCH_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            shadow_q     <= '0;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
            stall_q      <= 1'b0;
            mem_ce_q     <= 1'b0;
            mem_addr_q   <= '0;
            rd_pend_q    <= 1'b0;
            rd_idx_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            shadow_q     <= shadow_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            addr_err_q   <= addr_err_d;
            stall_q      <= stall_d;
            mem_ce_q     <= mem_ce_d;
            mem_addr_q   <= mem_addr_d;
            rd_pend_q    <= rd_pend_d;
            rd_idx_q     <= rd_idx_d;
        end
    end

    assign stall      = stall_q;
    assign mem_ce     = mem_ce_q;
    assign mem_addr   = mem_addr_q;
    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Scoreboard bench for inst_fetch_ctrl: a cycle-level request model predicts
// deliveries and memory traffic; a negedge monitor compares against the DUT.
module tb_inst_fetch_ctrl;
    import inst_fetch_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        ce;
    logic        stall;
    logic        mem_ce;
    logic [31:0] mem_addr;
    logic [7:0]  mem_data;
    logic [31:0] inst;
    logic        inst_valid;
    logic        addr_err;

    inst_fetch_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .ce         (ce),
        .stall      (stall),
        .mem_ce     (mem_ce),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .inst       (inst),
        .inst_valid (inst_valid),
        .addr_err   (addr_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Byte memory contents: fixed word at 0..3, hashed pattern elsewhere.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [7:0] tbl [4];
        tbl[0] = 8'h3C; tbl[1] = 8'h08; tbl[2] = 8'h12; tbl[3] = 8'h34;
        if (a < 32'd4) return tbl[a[1:0]];
        return 8'((a[7:0] * 8'd13) ^ a[15:8] ^ a[31:24] ^ 8'h5A);
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] base);
        logic [31:0] b;
        b = {base[31:2], 2'b00};
        return {mem_byte(b), mem_byte(b | 32'd1), mem_byte(b | 32'd2), mem_byte(b | 32'd3)};
    endfunction

    always @(posedge clk) begin
        if (mem_ce) mem_data <= mem_byte(mem_addr);
        else        mem_data <= 8'($urandom);
    end

    typedef struct {
        int          cyc;
        logic [31:0] word;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc      = 0;
    int          free_at  = 0;
    bit          f_act    = 1'b0;
    int          f_start  = 0;
    logic [31:0] f_base   = '0;
    logic [31:0] hold_inst = '0;
    bit          mon_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Request model: a cycle's request is accepted only when no fetch is owed.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            f_act     = 1'b0;
            hold_inst = '0;
            free_at   = cyc + 1;
        end else if (cyc >= free_at && ce) begin
            if (pc[1:0] == 2'b00) begin
                exp_q.push_back('{cyc: cyc + 6, word: word_at(pc), err: 1'b0});
                f_act   = 1'b1;
                f_start = cyc;
                f_base  = pc;
                free_at = cyc + 6;
            end else begin
                exp_q.push_back('{cyc: cyc + 1, word: 32'h0, err: 1'b1});
                free_at = cyc + 1;
            end
        end
        cyc = cyc + 1;
        mon_en = 1'b1;
    end

    // Monitor: compare every cycle away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            bit          e_stall, e_mce;
            logic [31:0] e_addr;
            exp_t        e;
            e_stall = f_act && cyc >= f_start + 1 && cyc <= f_start + 5;
            e_mce   = f_act && cyc >= f_start + 1 && cyc <= f_start + 4;
            e_addr  = e_mce ? {f_base[31:2], 2'(cyc - f_start - 1)} : 32'h0;
            chk("stall", 32'(stall), 32'(e_stall));
            chk("mem_ce", 32'(mem_ce), 32'(e_mce));
            chk("mem_addr", mem_addr, e_addr);
            if (inst_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 32'(inst_valid), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("valid_cycle", 32'(cyc), 32'(e.cyc));
                    chk("inst", inst, e.word);
                    chk("addr_err", 32'(addr_err), 32'(e.err));
                    hold_inst = e.word;
                end
            end else begin
                chk("addr_err_idle", 32'(addr_err), 32'h0);
                chk("inst_hold", inst, hold_inst);
                if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                    e = exp_q.pop_front();
                    chk("missing_valid", 32'(inst_valid), 32'h1);
                end
            end
        end
    end

    task automatic step(input logic r, input logic c, input logic [31:0] p);
        rst = r; ce = c; pc = p;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, CHIP_DISABLE, 32'h0);
    endtask

    initial begin
        logic        s;
        logic [31:0] p;
        rst = 1'b1; ce = CHIP_DISABLE; pc = '0;
        @(posedge clk); #1;
        step(1'b1, CHIP_DISABLE, 32'h0);
        step(1'b1, CHIP_DISABLE, 32'h0);
        idle(2);

        // Aligned fetch of the known word at address 0.
        step(1'b0, CHIP_ENABLE, 32'h0000_0000);
        idle(8);

        // Back-to-back with a PC that advances by 4 whenever stall is low.
        p = 32'h0;
        rst = 1'b0; ce = CHIP_ENABLE; pc = p;
        for (int i = 0; i < 19; i++) begin
            @(negedge clk); s = stall;
            @(posedge clk); #1;
            if (!s) p = p + 32'd4;
            pc = (i == 17) ? 32'h0 : p;
            ce = (i < 17);
        end
        idle(8);

        // Misaligned request.
        step(1'b0, CHIP_ENABLE, 32'h0000_0006);
        idle(3);

        // ce dropped during the second fetch cycle.
        step(1'b0, CHIP_ENABLE, 32'h0000_0100);
        step(1'b0, CHIP_ENABLE, 32'h0000_0104);
        idle(10);

        // Reset during the third fetch cycle, then a fresh fetch.
        step(1'b0, CHIP_ENABLE, 32'h0000_0200);
        idle(2);
        step(1'b1, CHIP_DISABLE, 32'h0);
        idle(2);
        step(1'b0, CHIP_ENABLE, 32'h0000_0200);
        idle(8);

        // Top of the address space: no wrap.
        step(1'b0, CHIP_ENABLE, 32'hFFFF_FFFC);
        idle(8);

        // Random traffic with occasional resets and misaligned requests.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] rp;
            rp = $urandom;
            if ($urandom_range(3) != 0) rp[1:0] = 2'b00;
            step(($urandom_range(99) == 0), ($urandom_range(1) == 1), rp);
        end
        idle(10);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_fetch_ctrl.md
# inst_fetch_ctrl

Instruction-fetch responder on the far side of the PC/chip-enable interface. It accepts a word address and fetch enable from the PC register and reads four bytes from a byte-wide synchronous instruction memory. It assembles them big-endian into a 32-bit instruction and raises `stall` so the PC holds until the word is delivered. It sits between the PC register and the IF/ID pipeline register.

## Interface
- `INST_ADDR_W`, 32, instruction address width (`InstAddrBus`)
- `INST_W`, 32, instruction width (`InstBus`)
- `clk` input 1: sole clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high (`RstEnable` = 1'b1).
- `pc` input INST_ADDR_W: fetch address from the PC register.
- `ce` input 1: fetch enable from the PC register (`ChipEnable` = 1'b1).
- `stall` output 1: high while a fetch is in progress; the PC register must not advance while it is high.
- `mem_ce` output 1: byte-memory read enable.
- `mem_addr` output INST_ADDR_W: byte address to memory.
- `mem_data` input 8: read data, valid the cycle after `mem_ce`/`mem_addr` are presented (1-cycle synchronous read).
- `inst` output INST_W: assembled instruction; holds its value between fetches.
- `inst_valid` output 1: one-cycle pulse when `inst` is updated.
- `addr_err` output 1: one-cycle pulse, concurrent with `inst_valid`, for a misaligned `pc`.

## Operation
- FSM states:
  - IDLE
  - FETCH (4 cycles; 2-bit counter `cnt` = 0..3)
  - LAST (1 cycle)
- **IDLE**
  - `ce`=1 and `pc[1:0]`=00: latch `addr_q`=`pc`, `cnt`=0, go to FETCH.
  - `ce`=1 and `pc[1:0]`≠00: no memory access, stay in IDLE. Next cycle: `inst`=0, `inst_valid`=1, `addr_err`=1.
  - `ce`=0: stay in IDLE.
- **FETCH**
  - `mem_ce`=1, `mem_addr`={`addr_q[31:2]`, `cnt`}, `cnt` increments each cycle.
  - From the second FETCH cycle on, capture `mem_data` for byte `cnt`-1.
  - After `cnt`=3, go to LAST.
- **LAST**
  - `mem_ce`=0; capture byte 3 from `mem_data`.
  - Go to IDLE; next cycle `inst_valid`=1.
- Byte placement, big-endian: byte at offset 0 goes to `inst[31:24]`, offset 1 to `[23:16]`, offset 2 to `[15:8]`, offset 3 to `[7:0]`.
- Bytes are collected in a shadow register. `inst` is written from it only at the LAST→IDLE edge, so `inst` never shows a partial word.
- `stall` = (state ≠ IDLE), decoded from registered state.
- Handshake with the PC register:
  - In the IDLE cycle where a fetch is accepted, `stall`=0, so the PC advances on the same edge that latches `addr_q`.
  - The PC then holds at `pc`+4 for the whole fetch.
- A `ce` deassert during FETCH/LAST does not abort: the fetch completes and is delivered.
- A new request may be accepted in the same IDLE cycle that `inst_valid` pulses.

## Timing
- Request accepted in cycle N (IDLE, `ce`=1). Memory addresses are issued in cycles N+1..N+4. `inst_valid`=1 in cycle N+6.
- Sustained throughput with `ce` held high: one instruction every 6 cycles.
- Misaligned request in cycle N: `inst_valid`/`addr_err` in cycle N+1; `stall` stays 0.
- Reset values, applied when `rst`=1 at any edge including mid-fetch:
  - state=IDLE, `cnt`=0, `addr_q`=0, shadow register=0
  - `inst`=0, `inst_valid`=0, `addr_err`=0
  - `stall`=0, `mem_ce`=0, `mem_addr`=0
  - Any fetch in progress is discarded with no `inst_valid`.
- `mem_addr` is 0 whenever `mem_ce`=0.
- Address arithmetic stays in the word: {`addr_q[31:2]`, `cnt`}, no carry into bit 2. `pc`=FFFFFFFC fetches FFFFFFFC..FFFFFFFF with no wrap.

## Structure
- Shared constants go in `defines.v`:
  - `RstEnable`, `ChipEnable`, `ChipDisable`
  - `InstAddrBus`, `InstBus`
  - new `ByteBus` (7:0)
  - FSM encodings `FetchIdle`, `FetchBusy`, `FetchLast` (2-bit)
- Single module with no sub-module. Byte capture is a 4-way decode on a delayed copy of `cnt`.

## Test plan
- **Aligned fetch:** reset, then `pc`=00000000 with `ce`=1; memory bytes 3C,08,12,34 at addresses 0..3 → `mem_addr` 0,1,2,3 in cycles N+1..N+4, `inst`=3C081234 with `inst_valid` in N+6, `stall`=1 for N+1..N+5.
- **Back-to-back:** `ce` held high with a pc model that advances by 4 when `stall`=0 → fetches at 0, 4, 8 with `inst_valid` pulses exactly 6 cycles apart and correct words.
- **Misaligned:** `pc`=00000006, `ce`=1 → no `mem_ce`; next cycle `inst`=0, `inst_valid`=1, `addr_err`=1, `stall`=0.
- **ce dropped mid-fetch:** `ce` falls in FETCH cycle 2 → fetch completes, `inst_valid` in N+6, then IDLE with no new request.
- **Reset mid-fetch:** `rst`=1 in FETCH cycle 3 → next cycle all outputs 0, no `inst_valid`; a fresh fetch afterwards returns the correct word.
- **Top of address space:** `pc`=FFFFFFFC → `mem_addr` FFFFFFFC..FFFFFFFF, no wrap to 0.
